// File: rtl/ula_sequencial.sv
// Multicycle ALU: latch the operands on Inicio, run EXECUTA (1 cycle) or MULTIPLICA (LARGURA cycles), then strobe Pronto in FIM.
// Optional feature macro: ULA_MULT_EN compiles in the shift-add multiplier; without it, opcode 110 returns 0.
module ula_sequencial #(
    parameter int LARGURA = 8
) (
    input  logic               Clock,
    input  logic               Resetn,
    input  logic               Inicio,
    input  logic [2:0]         Operacao,
    input  logic [LARGURA-1:0] Entrada1,
    input  logic [LARGURA-1:0] Entrada2,
    output logic               Ocupado,
    output logic               Pronto,
    output logic [LARGURA-1:0] Resultado,
    output logic               Carry,
    output logic               Zero
);

    typedef enum logic [1:0] {OCIOSO, EXECUTA, MULTIPLICA, FIM} estado_t;

    estado_t            estado_q;
    logic [2:0]         op_q;
    logic [LARGURA-1:0] a_q;
    logic [LARGURA-1:0] b_q;
    logic [LARGURA-1:0] res_q;
    logic               carry_q;
    logic               zero_q;
    logic               pronto_q;
    logic               ocupado_q;

    logic [LARGURA-1:0] alu_res;
    logic               alu_carry;

`ifdef ULA_MULT_EN
    localparam int CW = $clog2(LARGURA + 1);

    logic [2*LARGURA-1:0] mcand_q;
    logic [2*LARGURA-1:0] prod_q;
    logic [2*LARGURA-1:0] prod_d;
    logic [CW-1:0]        cnt_q;
    logic                 ultimo;

    // b_q is consumed LSB-first while the multiplicand walks left.
    assign prod_d = prod_q + (b_q[0] ? mcand_q : '0);
    assign ultimo = (cnt_q == CW'(LARGURA - 1));
`endif

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op_q)
            3'b000: alu_res = a_q & b_q;
            3'b001: alu_res = a_q | b_q;
            3'b010: alu_res = a_q ^ b_q;
            3'b011: alu_res = ~a_q;
            3'b100: {alu_carry, alu_res} = {1'b0, a_q} + {1'b0, b_q};
            3'b101: begin
                alu_res   = a_q - b_q;
                alu_carry = (a_q < b_q);
            end
            3'b111: begin
                alu_res   = {a_q[LARGURA-2:0], 1'b0};
                alu_carry = a_q[LARGURA-1];
            end
            default: begin
                alu_res   = '0;
                alu_carry = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            estado_q  <= OCIOSO;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            pronto_q  <= 1'b0;
            ocupado_q <= 1'b0;
`ifdef ULA_MULT_EN
            mcand_q   <= '0;
            prod_q    <= '0;
            cnt_q     <= '0;
`endif
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (Inicio) begin
                        op_q      <= Operacao;
                        a_q       <= Entrada1;
                        b_q       <= Entrada2;
                        ocupado_q <= 1'b1;
`ifdef ULA_MULT_EN
                        mcand_q   <= {{LARGURA{1'b0}}, Entrada1};
                        prod_q    <= '0;
                        cnt_q     <= '0;
                        estado_q  <= (Operacao == 3'b110) ? MULTIPLICA : EXECUTA;
`else
                        estado_q  <= EXECUTA;
`endif
                    end
                end
                EXECUTA: begin
                    res_q    <= alu_res;
                    carry_q  <= alu_carry;
                    zero_q   <= (alu_res == '0);
                    pronto_q <= 1'b1;
                    estado_q <= FIM;
                end
`ifdef ULA_MULT_EN
                MULTIPLICA: begin
                    prod_q  <= prod_d;
                    mcand_q <= mcand_q << 1;
                    b_q     <= b_q >> 1;
                    cnt_q   <= cnt_q + CW'(1);
                    if (ultimo) begin
                        res_q    <= prod_d[LARGURA-1:0];
                        carry_q  <= |prod_d[2*LARGURA-1:LARGURA];
                        zero_q   <= (prod_d[LARGURA-1:0] == '0);
                        pronto_q <= 1'b1;
                        estado_q <= FIM;
                    end
                end
`endif
                FIM: begin
                    pronto_q  <= 1'b0;
                    ocupado_q <= 1'b0;
                    estado_q  <= OCIOSO;
                end
                default: begin
                    pronto_q  <= 1'b0;
                    ocupado_q <= 1'b0;
                    estado_q  <= OCIOSO;
                end
            endcase
        end
    end

    assign Ocupado   = ocupado_q;
    assign Pronto    = pronto_q;
    assign Resultado = res_q;
    assign Carry     = carry_q;
    assign Zero      = zero_q;

endmodule

// File: tb/tb_ula_sequencial.sv
// Directed-vector bench for ula_sequencial; expected values are hand-computed for LARGURA=8 and follow ULA_MULT_EN.
module tb_ula_sequencial;

    localparam int W = 8;

    logic         Clock    = 1'b0;
    logic         Resetn   = 1'b0;
    logic         Inicio   = 1'b0;
    logic [2:0]   Operacao = 3'b000;
    logic [W-1:0] Entrada1 = '0;
    logic [W-1:0] Entrada2 = '0;
    logic         Ocupado;
    logic         Pronto;
    logic [W-1:0] Resultado;
    logic         Carry;
    logic         Zero;

    int vectors     = 0;
    int miscompares = 0;

    ula_sequencial #(.LARGURA(W)) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .Inicio    (Inicio),
        .Operacao  (Operacao),
        .Entrada1  (Entrada1),
        .Entrada2  (Entrada2),
        .Ocupado   (Ocupado),
        .Pronto    (Pronto),
        .Resultado (Resultado),
        .Carry     (Carry),
        .Zero      (Zero)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Start one operation at the next edge, scramble the operand inputs right after it,
    // and measure edges-to-Pronto plus the number of cycles Ocupado was high.
    task automatic run(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output int ocup);
        @(negedge Clock);
        Resetn   = 1'b1;
        Inicio   = 1'b1;
        Operacao = op;
        Entrada1 = a;
        Entrada2 = b;
        @(posedge Clock);
        #1;
        Inicio   = 1'b0;
        Operacao = 3'($urandom);
        Entrada1 = W'($urandom);
        Entrada2 = W'($urandom);
        lat  = 0;
        ocup = Ocupado ? 1 : 0;
        while (!Pronto && lat < 40) begin
            @(posedge Clock);
            #1;
            lat++;
            if (Ocupado) ocup++;
        end
        @(posedge Clock);
        #1;
        chk("pronto_one_cycle", Pronto, 0);
        chk("ocupado_back_idle", Ocupado, 0);
    endtask

    task automatic chk_res(input string tag, input logic [W-1:0] r, input logic c, input logic z);
        chk({tag, "_res"}, Resultado, r);
        chk({tag, "_carry"}, Carry, c);
        chk({tag, "_zero"}, Zero, z);
    endtask

    initial begin
        int lat;
        int ocup;
        int npronto;
        logic [W-1:0] mul_res;
        logic         mul_c;
        logic         mul_z;
        int           mul_lat;
        int           mul_ocup;
`ifdef ULA_MULT_EN
        mul_res = 8'h10; mul_c = 1'b1; mul_z = 1'b0; mul_lat = 8; mul_ocup = 9;
`else
        mul_res = 8'h00; mul_c = 1'b0; mul_z = 1'b1; mul_lat = 1; mul_ocup = 2;
`endif

        #12;
        chk("rst_ocupado", Ocupado, 0);
        chk("rst_pronto", Pronto, 0);
        chk_res("rst", 8'h00, 1'b0, 1'b0);

        run(3'b000, 8'hF0, 8'h3C, lat, ocup);
        chk("and_lat", lat, 1);
        chk("and_ocup", ocup, 2);
        chk_res("and", 8'h30, 1'b0, 1'b0);

        run(3'b100, 8'hFF, 8'h01, lat, ocup);
        chk_res("add", 8'h00, 1'b1, 1'b1);

        run(3'b101, 8'h05, 8'h07, lat, ocup);
        chk_res("sub", 8'hFE, 1'b1, 1'b0);

        run(3'b010, 8'hA5, 8'h0F, lat, ocup);
        chk_res("xor", 8'hAA, 1'b0, 1'b0);

        run(3'b110, 8'h10, 8'h11, lat, ocup);
        chk("mul_lat", lat, mul_lat);
        chk("mul_ocup", ocup, mul_ocup);
        chk_res("mul", mul_res, mul_c, mul_z);

        run(3'b110, 8'h0F, 8'h0F, lat, ocup);
`ifdef ULA_MULT_EN
        chk_res("mul_e1", 8'hE1, 1'b0, 1'b0);
`else
        chk_res("mul_e1", 8'h00, 1'b0, 1'b1);
`endif

        run(3'b111, 8'h81, 8'h00, lat, ocup);
        chk_res("shl", 8'h02, 1'b1, 1'b0);

        run(3'b011, 8'hFF, 8'h12, lat, ocup);
        chk_res("not", 8'h00, 1'b0, 1'b1);

        repeat (3) @(posedge Clock);
        #1;
        chk_res("hold", 8'h00, 1'b0, 1'b1);

        // Inicio pulsed while busy and again while in FIM must start nothing.
        @(negedge Clock);
        Inicio = 1'b1; Operacao = 3'b110; Entrada1 = 8'h10; Entrada2 = 8'h11;
        @(posedge Clock);
        npronto = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge Clock);
            if (Pronto) npronto++;
            Inicio   = (k == 1) || Pronto;
            Operacao = 3'b001;
            Entrada1 = 8'hFF;
            Entrada2 = 8'hFF;
        end
        Inicio = 1'b0;
        chk("ignore_pronto_count", npronto, 1);
        chk("ignore_ocupado", Ocupado, 0);
        chk_res("ignore", mul_res, mul_c, mul_z);

        // Asynchronous reset in the middle of a multiply.
        @(negedge Clock);
        Inicio = 1'b1; Operacao = 3'b110; Entrada1 = 8'h10; Entrada2 = 8'h11;
        @(posedge Clock);
        #1;
        Inicio = 1'b0;
        repeat (4) @(posedge Clock);
        #2;
        Resetn = 1'b0;
        #1;
        chk("midrst_ocupado", Ocupado, 0);
        chk("midrst_pronto", Pronto, 0);
        chk_res("midrst", 8'h00, 1'b0, 1'b0);
        @(negedge Clock);
        Resetn = 1'b1;
        npronto = 0;
        repeat (12) begin
            @(negedge Clock);
            if (Pronto) npronto++;
        end
        chk("midrst_no_pronto", npronto, 0);
        chk("midrst_idle", Ocupado, 0);

        // Inicio presented together with reset release is taken at the first edge.
        Resetn = 1'b0;
        run(3'b001, 8'h0F, 8'hF0, lat, ocup);
        chk("or_lat", lat, 1);
        chk("or_ocup", ocup, 2);
        chk_res("or", 8'hFF, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
